// File: rtl/access_ctrl_pkg.sv
// Shared constants and helpers for the one-hot mux pipeline.
// Provides buffer depth, occupancy width and a one-hot legality check.
package access_ctrl_pkg;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W = 2;
    localparam int MAX_CH = 16;

    function automatic logic onehot_legal(input logic [MAX_CH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction
endpackage

// File: rtl/onehot_mux_n.sv
// Combinational N:1 one-hot data mux.
// Output is forced to zero whenever the select is not exactly one-hot.
module onehot_mux_n
    import access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]                 sel,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]             out_data
);
    logic legal;

    always_comb begin
        legal = onehot_legal(MAX_CH'(sel));
        out_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (legal && sel[i]) begin
                out_data = out_data | in_data[i];
            end
        end
    end
endmodule

// File: rtl/onehot_mux_pipe.sv
// One-hot channel select into a 2-entry registered FIFO.
// Define ONEHOT_MUX_SEL_ERR_EN to add sticky sel_err with err_clr.
module onehot_mux_pipe
    import access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CH-1:0]                 sel,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]                 in_valid,
    output logic [NUM_CH-1:0]                 in_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CNT_W-1:0]                  count
`ifdef ONEHOT_MUX_SEL_ERR_EN
    ,
    input  logic                              err_clr,
    output logic                              sel_err
`endif
);
    logic                  legal;
    logic                  space;
    logic                  push;
    logic                  pop;
    logic                  wptr;
    logic                  rptr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] last_pop;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [CNT_W-1:0]      count_nxt;

    onehot_mux_n #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_CH    (NUM_CH)
    ) u_mux (
        .sel     (sel),
        .in_data (in_data),
        .out_data(wdata)
    );

    // Readiness depends only on sel and registered occupancy, never on out_ready.
    assign legal     = onehot_legal(MAX_CH'(sel));
    assign space     = count < CNT_W'(FIFO_DEPTH);
    assign in_ready  = (legal && space && rst_n) ? sel : '0;
    assign push      = |(in_valid & in_ready);
    assign out_valid = count != '0;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rptr] : last_pop;

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            count    <= '0;
            last_pop <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (pop) begin
                last_pop <= mem[rptr];
                rptr     <= ~rptr;
            end
            count <= count_nxt;
        end
    end

`ifdef ONEHOT_MUX_SEL_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (!legal && |in_valid) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_onehot_mux_pipe.sv
// Scoreboard bench for onehot_mux_pipe.
// Define ONEHOT_MUX_SEL_ERR_EN to also exercise sel_err.
module tb_onehot_mux_pipe;
    logic            clk;
    logic            rst_n;
    logic [3:0]      sel;
    logic [3:0][15:0] in_data;
    logic [3:0]      in_valid;
    logic [3:0]      in_ready;
    logic [15:0]     out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      count;
`ifdef ONEHOT_MUX_SEL_ERR_EN
    logic            err_clr;
    logic            sel_err;
`endif

    int          ncmp;
    int          nerr;
    int          mcnt;
    logic [15:0] sb[$];

    onehot_mux_pipe #(.DATA_WIDTH(16), .NUM_CH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
`ifdef ONEHOT_MUX_SEL_ERR_EN
        ,
        .err_clr  (err_clr),
        .sel_err  (sel_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        sel = 4'b0001;
        in_valid = 4'b0001;
        in_data = '0;
        out_ready = 1'b0;
`ifdef ONEHOT_MUX_SEL_ERR_EN
        err_clr = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        ncmp++;
        if (count !== 2'd0) begin
            nerr++; $display("FAIL reset_count: got %0d want 0", count);
        end
        ncmp++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        ncmp++;
        if (out_data !== 16'h0) begin
            nerr++; $display("FAIL reset_out_data: got %h want 0000", out_data);
        end
        ncmp++;
        if (in_ready !== 4'b0000) begin
            nerr++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
`ifdef ONEHOT_MUX_SEL_ERR_EN
        ncmp++;
        if (sel_err !== 1'b0) begin
            nerr++; $display("FAIL reset_sel_err: got %b want 0", sel_err);
        end
`endif
        in_valid = 4'b0000;
        cyc();
        rst_n = 1'b1;
        mcnt = 0;
    endtask

    task automatic test_single();
        sel = 4'b0010;
        in_data[1] = 16'hABCD;
        in_valid = 4'b0010;
        out_ready = 1'b1;
        @(negedge clk);
        ncmp++;
        if (in_ready !== 4'b0010) begin
            nerr++; $display("FAIL single_in_ready: got %b want 0010", in_ready);
        end
        ncmp++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL single_pre_valid: got %b want 0", out_valid);
        end
        sb.push_back(16'hABCD);
        cyc();
        in_valid = 4'b0000;
        ncmp++;
        if (out_valid !== 1'b1) begin
            nerr++; $display("FAIL single_out_valid: got %b want 1", out_valid);
        end
        ncmp++;
        if (out_data !== sb[0]) begin
            nerr++; $display("FAIL single_out_data: got %h want %h", out_data, sb[0]);
        end
        ncmp++;
        if (count !== 2'd1) begin
            nerr++; $display("FAIL single_count: got %0d want 1", count);
        end
        void'(sb.pop_front());
        cyc();
        ncmp++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            nerr++;
            $display("FAIL single_drain: got valid %b count %0d want 0 0", out_valid, count);
        end
        ncmp++;
        if (out_data !== 16'hABCD) begin
            nerr++; $display("FAIL single_hold: got %h want abcd", out_data);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] words [3];
        logic [3:0]  exp_rdy;
        logic [15:0] exp_d;
        int          wi;
        int          popped;
        words[0] = 16'h0001;
        words[1] = 16'h0002;
        words[2] = 16'h0003;
        wi = 0;
        popped = 0;
        sel = 4'b0001;
        out_ready = 1'b0;
        mcnt = 0;
        for (int c = 0; c < 12 && popped < 3; c++) begin
            if (c == 4) out_ready = 1'b1;
            in_valid = (wi < 3) ? 4'b0001 : 4'b0000;
            in_data[0] = (wi < 3) ? words[wi] : 16'h0;
            @(negedge clk);
            exp_rdy = (mcnt < 2) ? sel : 4'b0000;
            ncmp++;
            if (in_ready !== exp_rdy) begin
                nerr++;
                $display("FAIL bp_in_ready c%0d: got %b want %b", c, in_ready, exp_rdy);
            end
            ncmp++;
            if (count !== 2'(mcnt)) begin
                nerr++; $display("FAIL bp_count c%0d: got %0d want %0d", c, count, mcnt);
            end
            if (mcnt > 0 && out_ready) begin
                exp_d = sb.pop_front();
                ncmp++;
                if (out_valid !== 1'b1 || out_data !== exp_d) begin
                    nerr++;
                    $display("FAIL bp_out c%0d: got %b/%h want 1/%h", c, out_valid, out_data, exp_d);
                end
                popped++;
                mcnt--;
            end
            if (|(in_valid & exp_rdy)) begin
                sb.push_back(in_data[0]);
                wi++;
                mcnt++;
            end
            cyc();
        end
        in_valid = 4'b0000;
        ncmp++;
        if (popped != 3 || wi != 3) begin
            nerr++; $display("FAIL bp_total: got %0d out %0d in want 3 3", popped, wi);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  exp_rdy;
        logic [15:0] exp_d;
        int          k;
        int          popped;
        int          last_c;
        k = 0;
        popped = 0;
        last_c = -1;
        out_ready = 1'b1;
        mcnt = 0;
        for (int c = 0; c < 16 && popped < 8; c++) begin
            if (k < 8) begin
                sel = 4'b0001 << (k % 4);
                in_valid = 4'b1111;
                for (int j = 0; j < 4; j++) in_data[j] = 16'hDEAD;
                in_data[k % 4] = 16'h0100 + 16'(k);
            end else begin
                sel = 4'b0001;
                in_valid = 4'b0000;
            end
            @(negedge clk);
            exp_rdy = ($countones(sel) == 1 && mcnt < 2) ? sel : 4'b0000;
            ncmp++;
            if (in_ready !== exp_rdy) begin
                nerr++;
                $display("FAIL b2b_in_ready c%0d: got %b want %b", c, in_ready, exp_rdy);
            end
            if (mcnt > 0) begin
                exp_d = sb.pop_front();
                ncmp++;
                if (out_valid !== 1'b1 || out_data !== exp_d) begin
                    nerr++;
                    $display("FAIL b2b_out c%0d: got %b/%h want 1/%h", c, out_valid, out_data, exp_d);
                end
                ncmp++;
                if (last_c >= 0 && c != last_c + 1) begin
                    nerr++; $display("FAIL b2b_rate: got gap at c%0d want c%0d", c, last_c + 1);
                end
                last_c = c;
                popped++;
                mcnt--;
            end
            if (|(in_valid & exp_rdy)) begin
                sb.push_back(16'h0100 + 16'(k));
                k++;
                mcnt++;
            end
            cyc();
        end
        in_valid = 4'b0000;
        ncmp++;
        if (popped != 8) begin
            nerr++; $display("FAIL b2b_total: got %0d want 8", popped);
        end
    endtask

    task automatic test_illegal_sel();
        sel = 4'b0110;
        in_valid = 4'b0110;
        in_data[1] = 16'h1111;
        in_data[2] = 16'h2222;
        out_ready = 1'b1;
        @(negedge clk);
        ncmp++;
        if (in_ready !== 4'b0000) begin
            nerr++; $display("FAIL ill_in_ready: got %b want 0000", in_ready);
        end
        cyc();
        ncmp++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL ill_no_push: got count %0d valid %b want 0 0", count, out_valid);
        end
        sel = 4'b0000;
        @(negedge clk);
        ncmp++;
        if (in_ready !== 4'b0000) begin
            nerr++; $display("FAIL ill_zero_sel: got %b want 0000", in_ready);
        end
`ifdef ONEHOT_MUX_SEL_ERR_EN
        ncmp++;
        if (sel_err !== 1'b1) begin
            nerr++; $display("FAIL ill_sel_err_set: got %b want 1", sel_err);
        end
`endif
        cyc();
        sel = 4'b0001;
        in_valid = 4'b0000;
        cyc();
`ifdef ONEHOT_MUX_SEL_ERR_EN
        ncmp++;
        if (sel_err !== 1'b1) begin
            nerr++; $display("FAIL ill_sel_err_sticky: got %b want 1", sel_err);
        end
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        ncmp++;
        if (sel_err !== 1'b0) begin
            nerr++; $display("FAIL ill_sel_err_clr: got %b want 0", sel_err);
        end
`endif
        ncmp++;
        if (count !== 2'd0) begin
            nerr++; $display("FAIL ill_count: got %0d want 0", count);
        end
    endtask

    task automatic test_reset_mid();
        sel = 4'b0001;
        out_ready = 1'b0;
        in_valid = 4'b0001;
        in_data[0] = 16'h0055;
        cyc();
        in_data[0] = 16'h0066;
        cyc();
        in_valid = 4'b0000;
        ncmp++;
        if (count !== 2'd2) begin
            nerr++; $display("FAIL rst_mid_fill: got %0d want 2", count);
        end
        #2 rst_n = 1'b0;
        #1;
        ncmp++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            nerr++;
            $display("FAIL rst_mid_clear: got valid %b count %0d want 0 0", out_valid, count);
        end
        ncmp++;
        if (in_ready !== 4'b0000 || out_data !== 16'h0) begin
            nerr++;
            $display("FAIL rst_mid_outs: got rdy %b data %h want 0000 0000", in_ready, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        mcnt = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ncmp++;
            if (out_valid !== 1'b0) begin
                nerr++; $display("FAIL rst_mid_stale c%0d: got %b want 0", c, out_valid);
            end
        end
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_illegal_sel();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
